// File: rtl/fir_feeder.sv
// fir_feeder: sample FIFO plus coefficient loader driving a FIR core's x_n/tvalid/set_coeffs inputs.
// Define FIR_FEEDER_FLUSH_EN to follow each drained stream with NBR_OF_TAPS zero samples.
module fir_feeder #(
    parameter int TAP_SIZE    = 2,
    parameter int NBR_OF_TAPS = 8,
    parameter int X_N_SIZE    = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            coef_wr,
    input  logic [TAP_SIZE*NBR_OF_TAPS-1:0] coef_data,
    output logic                            coef_ready,
    input  logic                            smp_valid,
    input  logic [X_N_SIZE-1:0]             smp_data,
    output logic                            smp_ready,
    output logic [X_N_SIZE-1:0]             x_n,
    output logic                            s_axis_fir_tvalid,
    output logic                            s_set_coeffs,
    output logic                            coef_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NBR_OF_TAPS + 4);
`ifdef FIR_FEEDER_FLUSH_EN
    typedef enum logic [2:0] {IDLE, CONFIG, GAP, STREAM, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, CONFIG, GAP, STREAM} state_t;
`endif
    state_t                            state;
    logic [X_N_SIZE-1:0]               mem [FIFO_DEPTH];
    logic [AW:0]                       wr, rd, occ_nxt;
    logic [TAP_SIZE*NBR_OF_TAPS-1:0]   coef_lat, coef_src;
    logic [X_N_SIZE-1:0]               w0, w1, w2;
    logic [CW-1:0]                     cnt;
    logic                              pending, push, pop, empty, accept;
    assign empty   = wr == rd;
    assign push    = smp_valid && smp_ready;
    assign accept  = coef_wr && coef_ready;
    assign pop     = !empty && !pending && (state == IDLE || state == STREAM);
    assign occ_nxt = wr - rd + (AW+1)'(push) - (AW+1)'(pop);
    // A request accepted on the very edge the load starts must supply the first word too
    assign coef_src = accept ? coef_data : coef_lat;
    assign w0 = X_N_SIZE'({coef_src[6*TAP_SIZE +: TAP_SIZE], coef_src[7*TAP_SIZE +: TAP_SIZE], {TAP_SIZE{1'b0}}});
    assign w1 = X_N_SIZE'({coef_lat[3*TAP_SIZE +: TAP_SIZE], coef_lat[4*TAP_SIZE +: TAP_SIZE], coef_lat[5*TAP_SIZE +: TAP_SIZE]});
    assign w2 = X_N_SIZE'({coef_lat[0 +: TAP_SIZE], coef_lat[TAP_SIZE +: TAP_SIZE], coef_lat[2*TAP_SIZE +: TAP_SIZE]});
    always_ff @(posedge clk) begin
        if (push) mem[wr[AW-1:0]] <= smp_data;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr        <= '0;
            rd        <= '0;
            smp_ready <= 1'b0;
        end else begin
            wr        <= wr + (AW+1)'(push);
            rd        <= rd + (AW+1)'(pop);
            smp_ready <= occ_nxt != (AW+1)'(FIFO_DEPTH);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            pending           <= 1'b0;
            coef_lat          <= '0;
            coef_err          <= 1'b0;
            coef_ready        <= 1'b0;
            x_n               <= '0;
            s_axis_fir_tvalid <= 1'b0;
            s_set_coeffs      <= 1'b0;
        end else begin
            if (accept) begin
                coef_lat <= coef_data;
                pending  <= 1'b1;
            end
            if (coef_wr && !coef_ready) coef_err <= 1'b1;
            x_n               <= '0;
            s_axis_fir_tvalid <= 1'b0;
            s_set_coeffs      <= 1'b0;
            coef_ready        <= 1'b0;
            case (state)
                IDLE:
                    if (pending) begin
                        state        <= CONFIG;
                        cnt          <= '0;
                        x_n          <= w0;
                        s_set_coeffs <= 1'b1;
                    end else if (pop) begin
                        state             <= STREAM;
                        x_n               <= mem[rd[AW-1:0]];
                        s_axis_fir_tvalid <= 1'b1;
                        coef_ready        <= 1'b1;
                    end else begin
                        coef_ready <= 1'b1;
                    end
                CONFIG:
                    if (cnt == CW'(2)) begin
                        state <= GAP;
                    end else begin
                        cnt          <= cnt + 1'b1;
                        x_n          <= cnt == '0 ? w1 : w2;
                        s_set_coeffs <= 1'b1;
                    end
                GAP: begin
                    state      <= IDLE;
                    pending    <= 1'b0;
                    coef_ready <= 1'b1;
                end
                STREAM:
                    if (pop) begin
                        x_n               <= mem[rd[AW-1:0]];
                        s_axis_fir_tvalid <= 1'b1;
                        coef_ready        <= 1'b1;
`ifdef FIR_FEEDER_FLUSH_EN
                    end else if (!pending) begin
                        state             <= FLUSH;
                        cnt               <= '0;
                        s_axis_fir_tvalid <= 1'b1;
`endif
                    end else begin
                        state      <= IDLE;
                        coef_ready <= 1'b1;
                    end
`ifdef FIR_FEEDER_FLUSH_EN
                FLUSH:
                    if (cnt == CW'(NBR_OF_TAPS - 1)) begin
                        state      <= IDLE;
                        coef_ready <= 1'b1;
                    end else begin
                        cnt               <= cnt + 1'b1;
                        s_axis_fir_tvalid <= 1'b1;
                    end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: scenario tasks plus randomized traffic checked against a queue-based output-plan model.
module tb_fir_feeder;
    logic        clk = 1'b0, reset_n = 1'b0, coef_wr = 1'b0, smp_valid = 1'b0;
    logic [15:0] coef_data = '0;
    logic [5:0]  smp_data = '0, x_n;
    logic        coef_ready, smp_ready, s_axis_fir_tvalid, s_set_coeffs, coef_err;
    logic [10:0] obs, exp_o = '0;
    logic [8:0]  plan [$];
    logic [5:0]  m_q [$];
    logic        m_pend, m_strm, m_err;
    logic [15:0] m_coef;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    fir_feeder dut (
        .clk(clk), .reset_n(reset_n), .coef_wr(coef_wr), .coef_data(coef_data),
        .coef_ready(coef_ready), .smp_valid(smp_valid), .smp_data(smp_data),
        .smp_ready(smp_ready), .x_n(x_n), .s_axis_fir_tvalid(s_axis_fir_tvalid),
        .s_set_coeffs(s_set_coeffs), .coef_err(coef_err)
    );

    assign obs = {coef_ready, smp_ready, s_axis_fir_tvalid, s_set_coeffs, coef_err, x_n};

    function automatic logic [1:0] tap(input logic [15:0] c, input int j);
        return c[2*j +: 2];
    endfunction

    // Plan records are {coef_ready, tvalid, set_coeffs, x_n}; fixed-length bursts are queued whole.
    always @(posedge clk or negedge reset_n) begin : model
        logic op, acc;
        logic [8:0] r;
        if (!reset_n) begin
            plan.delete();
            m_q.delete();
            m_pend = 0; m_strm = 0; m_err = 0; m_coef = '0; exp_o = '0;
        end else begin
            op  = m_pend;
            acc = coef_wr && exp_o[10];
            if (coef_wr && !exp_o[10]) m_err = 1;
            if (acc) begin
                m_coef = coef_data;
                m_pend = 1;
            end
            if (plan.size() > 0) r = plan.pop_front();
            else if (op && !m_strm) begin
                r = {3'b001, tap(m_coef, 6), tap(m_coef, 7), 2'b00};
                plan.push_back({3'b001, tap(m_coef, 3), tap(m_coef, 4), tap(m_coef, 5)});
                plan.push_back({3'b001, tap(m_coef, 0), tap(m_coef, 1), tap(m_coef, 2)});
                plan.push_back(9'h000);
                plan.push_back(9'h100);
                m_pend = 0;
            end else if (!op && m_q.size() > 0) begin
                r = {3'b110, m_q.pop_front()};
                m_strm = 1;
`ifdef FIR_FEEDER_FLUSH_EN
            end else if (m_strm && !op) begin
                r = 9'h080;
                repeat (7) plan.push_back(9'h080);
                plan.push_back(9'h100);
                m_strm = 0;
`endif
            end else begin
                r = 9'h100;
                m_strm = 0;
            end
            if (smp_valid && exp_o[9]) m_q.push_back(smp_data);
            exp_o = {r[8], m_q.size() < 4, r[7:6], m_err, r[5:0]};
        end
    end

    task automatic tick(input logic cw, input logic [15:0] cd, input logic sv, input logic [5:0] sd);
        coef_wr = cw; coef_data = cd; smp_valid = sv; smp_data = sd;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            n_cmp++; if (obs !== 11'd0) begin n_err++; $display("FAIL reset_state got %h want 000", obs); end
        end
        reset_n = 1;
        tick(0, 0, 0, 0);
        n_cmp++; if (obs !== 11'b110_0000_0000) begin n_err++; $display("FAIL reset_release got %h want 600", obs); end
        n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL reset_model got %h want %h", obs, exp_o); end
    endtask

    task automatic test_coef_load;
        logic [5:0] xe [4];
        logic [3:0] se;
        xe = '{6'b010000, 6'b000100, 6'b010001, 6'b000000};
        se = 4'b0111;
        tick(1, 16'h1111, 0, 0);
        n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL load_model got %h want %h", obs, exp_o); end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            n_cmp++;
            if ({s_set_coeffs, s_axis_fir_tvalid, x_n} !== {se[i], 1'b0, xe[i]}) begin
                n_err++; $display("FAIL load_word%0d got %b want %b", i, {s_set_coeffs, s_axis_fir_tvalid, x_n}, {se[i], 1'b0, xe[i]});
            end
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL load_model%0d got %h want %h", i, obs, exp_o); end
        end
        tick(0, 0, 0, 0);
        n_cmp++; if (coef_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_after_gap got %b want 1", coef_ready); end
    endtask

    task automatic test_stream;
        logic [5:0] v [3];
        logic       et;
        logic [5:0] ex;
        v = '{6'd5, 6'(-3), 6'd7};
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, i < 3, v[i % 3]);
            et = i >= 1 && i <= 3;
            ex = et ? v[(i + 2) % 3] : 6'd0;
            n_cmp++;
            if ({s_axis_fir_tvalid, x_n} !== {et, ex}) begin
                n_err++; $display("FAIL stream_cyc%0d got %b want %b", i, {s_axis_fir_tvalid, x_n}, {et, ex});
            end
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL stream_model%0d got %h want %h", i, obs, exp_o); end
        end
    endtask

    task automatic test_fifo_full;
        logic [5:0] got [$];
        tick(1, 16'($urandom), 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1, 6'(i + 1));
            n_cmp++; if (smp_ready !== (i < 3)) begin n_err++; $display("FAIL full_ready%0d got %b want %b", i, smp_ready, i < 3); end
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL full_model%0d got %h want %h", i, obs, exp_o); end
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 0);
            if (s_axis_fir_tvalid) got.push_back(x_n);
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL full_drain%0d got %h want %h", i, obs, exp_o); end
        end
        n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL full_count got %0d want 4", got.size()); end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            n_cmp++; if (got[k] !== 6'(k + 1)) begin n_err++; $display("FAIL full_order%0d got %0d want %0d", k, got[k], k + 1); end
        end
    endtask

    task automatic test_coef_err;
        tick(1, 16'hA5C3, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 16'hFFFF, 0, 0);
        n_cmp++; if (coef_err !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", coef_err); end
        n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL err_model got %h want %h", obs, exp_o); end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 0);
            n_cmp++; if (coef_err !== 1'b1) begin n_err++; $display("FAIL err_sticky%0d got %b want 1", i, coef_err); end
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL err_model%0d got %h want %h", i, obs, exp_o); end
        end
    endtask

    task automatic test_mid_stream;
        logic [5:0] got [$];
        int nset;
        nset = 0;
        tick(1, 16'h0F0F, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 6'(10 + i));
        tick(0, 0, 0, 0);
        tick(1, 16'h3C3C, 0, 0);
        got.push_back(x_n);
        n_cmp++; if ({s_axis_fir_tvalid, x_n} !== {1'b1, 6'd10}) begin n_err++; $display("FAIL mid_first got %b want 1001010", {s_axis_fir_tvalid, x_n}); end
        tick(0, 0, 0, 0);
        n_cmp++; if ({s_axis_fir_tvalid, s_set_coeffs} !== 2'b00) begin n_err++; $display("FAIL mid_drop got %b want 00", {s_axis_fir_tvalid, s_set_coeffs}); end
        for (int i = 0; i < 9; i++) begin
            tick(0, 0, 0, 0);
            if (s_axis_fir_tvalid) got.push_back(x_n);
            if (s_set_coeffs) nset++;
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL mid_model%0d got %h want %h", i, obs, exp_o); end
        end
        n_cmp++; if (nset != 3) begin n_err++; $display("FAIL mid_cfg_cycles got %0d want 3", nset); end
        n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL mid_count got %0d want 4", got.size()); end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            n_cmp++; if (got[k] !== 6'(10 + k)) begin n_err++; $display("FAIL mid_order%0d got %0d want %0d", k, got[k], 10 + k); end
        end
    endtask

    task automatic test_reset_mid_config;
        tick(1, 16'h5555, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_cmp++; if ({s_set_coeffs, x_n} !== 7'b1010101) begin n_err++; $display("FAIL rcfg_cycle1 got %b want 1010101", {s_set_coeffs, x_n}); end
        #2 reset_n = 0;
        #1;
        n_cmp++; if (obs !== 11'd0) begin n_err++; $display("FAIL rcfg_immediate got %h want 000", obs); end
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 0);
            n_cmp++; if (s_set_coeffs !== 1'b0) begin n_err++; $display("FAIL rcfg_no_set%0d got %b want 0", i, s_set_coeffs); end
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL rcfg_model%0d got %h want %h", i, obs, exp_o); end
        end
    endtask

`ifdef FIR_FEEDER_FLUSH_EN
    task automatic test_flush;
        int nz, nv;
        nz = 0; nv = 0;
        tick(0, 0, 1, 6'd9);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0);
            if (s_axis_fir_tvalid && x_n == 6'd0) nz++;
            if (s_axis_fir_tvalid && x_n == 6'd9) nv++;
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL flush_model%0d got %h want %h", i, obs, exp_o); end
        end
        n_cmp++; if (nz != 8 || nv != 1) begin n_err++; $display("FAIL flush_words got %0d zero %0d data want 8 1", nz, nv); end
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) reset_n = 0;
            tick($urandom_range(0, 11) == 0, 16'($urandom), $urandom_range(0, 2) != 0, 6'($urandom));
            reset_n = 1;
            n_cmp++; if (obs !== exp_o) begin n_err++; $display("FAIL random_cyc%0d got %h want %h", i, obs, exp_o); end
        end
    endtask

    initial begin
        test_reset;
        test_coef_load;
        test_stream;
        test_fifo_full;
        test_coef_err;
        test_mid_stream;
        test_reset_mid_config;
`ifdef FIR_FEEDER_FLUSH_EN
        test_flush;
`endif
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fir_feeder.md
FIR_FEEDER -- requirements
Module: fir_feeder

Interface
REQ-001 Parameter TAP_SIZE, default 2: coefficient width in bits.
REQ-002 Parameter NBR_OF_TAPS, default 8: number of taps.
REQ-003 Parameter X_N_SIZE, default 6: sample and config word width.
REQ-004 Parameter FIFO_DEPTH, default 4: sample FIFO entries; SHALL be a power of two.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 coef_wr  in  1  one-cycle request to load coef_data.
REQ-008 coef_data  in  TAP_SIZE*NBR_OF_TAPS  tap j in bits [2j+1:2j].
REQ-009 coef_ready  out  1  high when coef_wr will be accepted.
REQ-010 smp_valid  in  1  host sample valid.
REQ-011 smp_data  in  X_N_SIZE  signed host sample.
REQ-012 smp_ready  out  1  high when the FIFO is not full.
REQ-013 x_n  out  X_N_SIZE  word driven to the FIR.
REQ-014 s_axis_fir_tvalid  out  1  FIR sample valid.
REQ-015 s_set_coeffs  out  1  FIR coefficient-shift enable.
REQ-016 coef_err  out  1  sticky flag: coef_wr was dropped.

Function
REQ-017 All outputs SHALL be registered; x_n SHALL be 0 whenever tvalid and s_set_coeffs are both low.
REQ-018 FSM states SHALL be IDLE, CONFIG, GAP and STREAM.
REQ-019 A sample SHALL be written to the FIFO on any edge where smp_valid and smp_ready are both high.
REQ-020 coef_wr SHALL be accepted when coef_ready is high, which SHALL hold in IDLE and STREAM only; acceptance latches coef_data and sets a pending flag.
REQ-021 A coef_wr while coef_ready is low SHALL be dropped and SHALL set coef_err.
REQ-022 IDLE -> CONFIG SHALL happen when the pending flag is set; pending has priority over a non-empty FIFO.
REQ-023 IDLE -> STREAM SHALL happen when the FIFO is non-empty and nothing is pending.
REQ-024 CONFIG SHALL last exactly 3 cycles with s_set_coeffs=1 and tvalid=0.
REQ-025 CONFIG cycle 0 SHALL drive {tap6,tap7,2'b00}, cycle 1 {tap3,tap4,tap5} and cycle 2 {tap0,tap1,tap2}; the lowest-index tap of each word goes in x_n[5:4].
REQ-026 GAP SHALL last exactly one cycle with both strobes low; it then returns to IDLE and clears pending.
REQ-027 STREAM SHALL pop one FIFO entry per cycle with tvalid=1, so a write at edge N reaches x_n at edge N+1 when the FIFO was empty in IDLE.
REQ-028 STREAM SHALL exit to IDLE on the edge where the FIFO would otherwise be empty or pending is set; tvalid=0 on that cycle.
REQ-029 A simultaneous FIFO write and pop SHALL keep the occupancy constant; a write while full SHALL be impossible because smp_ready=0.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit to tell full from empty.

Reset
REQ-031 On reset_n=0 the block SHALL immediately clear all outputs, the FIFO pointers, the pending flag and coef_err, and SHALL enter IDLE.
REQ-032 A reset mid-CONFIG SHALL abort the load with no further s_set_coeffs; a reset mid-STREAM SHALL discard all FIFO contents.

Configuration
REQ-033 Macro FIR_FEEDER_FLUSH_EN defined: each STREAM exit caused by an empty FIFO SHALL be followed by a FLUSH state driving NBR_OF_TAPS cycles of x_n=0 with tvalid=1, then IDLE.
REQ-034 In FLUSH, a pending coef request or a new sample SHALL NOT interrupt the flush, and coef_ready SHALL be 0.
REQ-035 Macro FIR_FEEDER_FLUSH_EN undefined: no FLUSH state SHALL exist and behaviour is as in REQ-028.

Verification
REQ-036 Reset, then coef_wr with coef_data=16'h1111 -> s_set_coeffs high for 3 cycles; x_n=6'b010000, 6'b000100, 6'b010001; then 1 GAP cycle.
REQ-037 Write samples 5,-3,7 on consecutive cycles from IDLE -> tvalid high 3 cycles, x_n=5,-3,7 starting 1 cycle after the first write.
REQ-038 Write 5 samples with no pops possible (hold in CONFIG) -> smp_ready low after the 4th; the 5th is not written.
REQ-039 coef_wr during CONFIG -> dropped; coef_err=1 until reset.
REQ-040 coef_wr mid-STREAM with 3 samples queued -> tvalid drops for 1 cycle, then 3 CONFIG cycles and 1 GAP cycle, then streaming resumes with the remaining samples in order.
REQ-041 reset_n pulsed low mid-CONFIG cycle 1 -> s_set_coeffs=0 the same cycle; with FIR_FEEDER_FLUSH_EN, one sample followed by empty -> 8 zero words with tvalid=1.
